// File: rtl/layer_feeder_pkg.sv
// Shared constants, fill-state encoding and lane helper for the layer activation feeder.
package layer_feeder_pkg;

  localparam int DW       = 16;
  localparam int N_IN     = 15;
  localparam int NODE_LAT = 3;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } fill_state_t;

  function automatic logic [DW-1:0] lane_of(input logic [N_IN*DW-1:0] bus, input int k);
    return bus[k*DW +: DW];
  endfunction

endpackage

// File: rtl/layer_feeder_if.sv
// Serial activation stream in, held parallel activation bus and status pulses out.
interface layer_feeder_if import layer_feeder_pkg::*; ();

  logic [DW-1:0]      s_data;
  logic               s_valid;
  logic               s_last;
  logic               s_ready;
  logic [N_IN*DW-1:0] a_bus;
  logic               a_valid;
  logic               res_valid;
  logic               short_frm;
  logic [15:0]        frame_cnt;

  modport master (
    output s_data, s_valid, s_last,
    input  s_ready, a_bus, a_valid, res_valid, short_frm, frame_cnt
  );

  modport slave (
    input  s_data, s_valid, s_last,
    output s_ready, a_bus, a_valid, res_valid, short_frm, frame_cnt
  );

endinterface

// File: rtl/layer_feeder.sv
// Gathers a serial frame of activations into a write buffer and swaps it onto a
// held parallel bus, pacing swaps so the node pipeline has drained before the next.
module layer_feeder import layer_feeder_pkg::*; (
  input  logic           clk,
  input  logic           reset,
  layer_feeder_if.slave  bus
);

  localparam int WCNT_W = $clog2(N_IN);
  localparam int LAT_W  = $clog2(NODE_LAT + 1);

  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(N_IN - 1);
  localparam logic [WCNT_W-1:0] WCNT_ONE = WCNT_W'(1);
  localparam logic [LAT_W-1:0]  LAT_LOAD = LAT_W'(NODE_LAT);
  localparam logic [LAT_W-1:0]  LAT_ONE  = LAT_W'(1);

  fill_state_t                state;
  logic [WCNT_W-1:0]          wcnt;
  logic [LAT_W-1:0]           lat_cnt;
  logic [N_IN-1:0][DW-1:0]    wbuf;
  logic [N_IN-1:0][DW-1:0]    a_reg;
  logic                       a_valid_r;
  logic                       res_valid_r;
  logic                       short_frm_r;
  logic [15:0]                frame_cnt_r;
  logic                       take;

  assign take = bus.s_valid && (state == FILL);

  // A full buffer is only swapped out once lat_cnt has drained, so the previous
  // frame's node results are never cut short and a held frame is never overwritten.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= FILL;
      wcnt        <= '0;
      lat_cnt     <= '0;
      wbuf        <= '0;
      a_reg       <= '0;
      a_valid_r   <= 1'b0;
      res_valid_r <= 1'b0;
      short_frm_r <= 1'b0;
      frame_cnt_r <= '0;
    end else begin
      a_valid_r   <= 1'b0;
      short_frm_r <= 1'b0;
      res_valid_r <= (lat_cnt == LAT_ONE);
      if (lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_ONE;
      end
      case (state)
        FILL: begin
          if (take) begin
            wbuf[wcnt] <= bus.s_data;
            wcnt       <= wcnt + WCNT_ONE;
            if (wcnt == LAST_IDX) begin
              state <= FULL;
            end else if (bus.s_last) begin
              state       <= FULL;
              short_frm_r <= 1'b1;
            end
          end
        end
        FULL: begin
          if (lat_cnt == '0) begin
            a_reg       <= wbuf;
            wbuf        <= '0;
            wcnt        <= '0;
            state       <= FILL;
            lat_cnt     <= LAT_LOAD;
            frame_cnt_r <= frame_cnt_r + 16'd1;
            a_valid_r   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.s_ready   = (state == FILL);
  assign bus.a_bus     = a_reg;
  assign bus.a_valid   = a_valid_r;
  assign bus.res_valid = res_valid_r;
  assign bus.short_frm = short_frm_r;
  assign bus.frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_layer_feeder.sv
// Randomised and directed bench for layer_feeder, checked every cycle against a
// frame-level timing model plus literal expectations for the directed cases.
module tb_layer_feeder;
  import layer_feeder_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  layer_feeder_if lf_if ();

  layer_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (lf_if)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Frame-level model: a frame closing at cycle c appears at max(c+2, prev+NODE_LAT+1).
  logic [DW-1:0]      cur_w [N_IN];
  int                 cur_n;
  bit                 pending;
  logic [N_IN*DW-1:0] pend_bus;
  int                 pend_av;
  int                 last_av;
  int                 res_at;
  int                 short_at;
  logic [N_IN*DW-1:0] exp_bus;
  logic [15:0]        exp_cnt;
  bit                 exp_av;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    cur_n    = 0;
    pending  = 1'b0;
    pend_bus = '0;
    pend_av  = -100;
    last_av  = -100;
    res_at   = -100;
    short_at = -100;
    exp_bus  = '0;
    exp_cnt  = '0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_clear();
        check("rst_a_bus", 256'(lf_if.a_bus), 256'(0));
        check("rst_a_valid", 256'(lf_if.a_valid), 256'(0));
      end else begin
        exp_av = pending && (pend_av == cyc);
        if (exp_av) begin
          exp_bus = pend_bus;
          exp_cnt = exp_cnt + 16'd1;
          res_at  = cyc + NODE_LAT;
          last_av = cyc;
          pending = 1'b0;
        end
        check("a_valid", 256'(lf_if.a_valid), 256'(exp_av));
        check("res_valid", 256'(lf_if.res_valid), 256'(res_at == cyc));
        check("short_frm", 256'(lf_if.short_frm), 256'(short_at == cyc));
        check("s_ready", 256'(lf_if.s_ready), 256'(!pending));
        check("a_bus", 256'(lf_if.a_bus), 256'(exp_bus));
        check("frame_cnt", 256'(lf_if.frame_cnt), 256'(exp_cnt));
        if (lf_if.s_valid && !pending) begin
          cur_w[cur_n] = lf_if.s_data;
          cur_n++;
          if (cur_n == N_IN || lf_if.s_last) begin
            pend_bus = '0;
            for (int k = 0; k < cur_n; k++) pend_bus[k*DW +: DW] = cur_w[k];
            pending = 1'b1;
            pend_av = (cyc + 2 > last_av + NODE_LAT + 1) ? cyc + 2 : last_av + NODE_LAT + 1;
            if (cur_n < N_IN) short_at = cyc + 1;
            cur_n = 0;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [DW-1:0] d, input logic last);
    int guard;
    guard = 0;
    lf_if.s_data  = d;
    lf_if.s_valid = 1'b1;
    lf_if.s_last  = last;
    @(negedge clk);
    while (!lf_if.s_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) check("s_ready_timeout", 256'(lf_if.s_ready), 256'(1));
    @(posedge clk);
    #1;
    lf_if.s_valid = 1'b0;
    lf_if.s_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    lf_if.s_valid = 1'b0;
    lf_if.s_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input int bound, output int at);
    int g;
    g = 0;
    @(negedge clk);
    while (!lf_if.a_valid && g < bound) begin
      @(negedge clk);
      g++;
    end
    check("wait_a_valid", 256'(lf_if.a_valid), 256'(1));
    at = cyc;
  endtask

  int av1;
  int av2;
  int len;

  initial begin
    lf_if.s_data  = '0;
    lf_if.s_valid = 1'b0;
    lf_if.s_last  = 1'b0;
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;

    @(negedge clk);
    $display("[TB] reset state");
    check("t1_a_bus", 256'(lf_if.a_bus), 256'(0));
    check("t1_a_valid", 256'(lf_if.a_valid), 256'(0));
    check("t1_res_valid", 256'(lf_if.res_valid), 256'(0));
    check("t1_short_frm", 256'(lf_if.short_frm), 256'(0));
    check("t1_frame_cnt", 256'(lf_if.frame_cnt), 256'(0));
    check("t1_s_ready", 256'(lf_if.s_ready), 256'(1));
    @(posedge clk);
    #1;

    $display("[TB] full frame 1..15");
    for (int k = 1; k <= N_IN; k++) applyStimulus(DW'(k), k == N_IN);
    @(negedge clk);
    check("t2_stall_ready", 256'(lf_if.s_ready), 256'(0));
    check("t2_no_early_av", 256'(lf_if.a_valid), 256'(0));
    @(negedge clk);
    check("t2_a_valid", 256'(lf_if.a_valid), 256'(1));
    for (int k = 0; k < N_IN; k++) check("t2_lane", 256'(lane_of(lf_if.a_bus, k)), 256'(k + 1));
    check("t2_frame_cnt", 256'(lf_if.frame_cnt), 256'(1));
    @(negedge clk);
    check("t2_res_early1", 256'(lf_if.res_valid), 256'(0));
    @(negedge clk);
    check("t2_res_early2", 256'(lf_if.res_valid), 256'(0));
    @(negedge clk);
    check("t2_res_valid", 256'(lf_if.res_valid), 256'(1));
    @(posedge clk);
    #1;

    $display("[TB] back-to-back frames");
    for (int k = 0; k < N_IN; k++) applyStimulus(DW'(16 + k), k == N_IN - 1);
    checkOutput(20, av1);
    check("t3_lane0", 256'(lane_of(lf_if.a_bus, 0)), 256'(16));
    check("t3_lane14", 256'(lane_of(lf_if.a_bus, 14)), 256'(30));
    @(posedge clk);
    #1;
    applyStimulus(16'h0abc, 1'b1);
    checkOutput(20, av2);
    check("t3_spacing", 256'(av2 - av1), 256'(NODE_LAT + 1));
    check("t3_single_lane0", 256'(lane_of(lf_if.a_bus, 0)), 256'(16'h0abc));
    check("t3_single_lane1", 256'(lane_of(lf_if.a_bus, 1)), 256'(0));
    @(posedge clk);
    #1;

    $display("[TB] short frame of negatives");
    idle(6);
    for (int k = 1; k <= 5; k++) applyStimulus(DW'(-k), k == 5);
    @(negedge clk);
    check("t4_short_frm", 256'(lf_if.short_frm), 256'(1));
    checkOutput(20, av1);
    for (int k = 0; k < N_IN; k++)
      check("t4_lane", 256'(lane_of(lf_if.a_bus, k)), (k < 5) ? 256'(16'hffff - 16'(k)) : 256'(0));
    @(posedge clk);
    #1;

    $display("[TB] reset mid-frame");
    idle(6);
    for (int k = 0; k < 7; k++) applyStimulus(DW'(200 + k), 1'b0);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("t5_bus_cleared", 256'(lf_if.a_bus), 256'(0));
      check("t5_no_av", 256'(lf_if.a_valid), 256'(0));
    end
    @(posedge clk);
    #1 reset = 1'b1;
    idle(5);
    check("t5_cnt_cleared", 256'(lf_if.frame_cnt), 256'(0));
    for (int k = 0; k < N_IN; k++) applyStimulus(DW'(300 + k), 1'b0);
    checkOutput(20, av1);
    check("t5_lane0", 256'(lane_of(lf_if.a_bus, 0)), 256'(300));
    check("t5_lane6", 256'(lane_of(lf_if.a_bus, 6)), 256'(306));
    check("t5_frame_cnt", 256'(lf_if.frame_cnt), 256'(1));
    @(posedge clk);
    #1;

    $display("[TB] random frames with gaps");
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    idle(2);
    for (int f = 0; f < 100; f++) begin
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 14)) : N_IN;
      for (int w = 0; w < len; w++) begin
        if ($urandom_range(0, 9) < 3) idle(1 + int'($urandom_range(0, 2)));
        applyStimulus(DW'($urandom), (w == len - 1) && ((len < N_IN) || ($urandom_range(0, 1) == 1)));
      end
    end
    idle(20);
    check("t6_frame_cnt", 256'(lf_if.frame_cnt), 256'(100));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before timeout");
    $fatal(1);
  end

endmodule
